// File: rtl/bp_update_scheduler_pkg.sv
// Shared types and constants for the branch-predictor update scheduler.
// An entry is one resolved branch: its PC and its outcome.
package bp_pkg;

  localparam int BP_WIDTH_DFLT = 2;
  localparam int ENTRY_W       = 33;
  localparam int IDX_LO        = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } bp_entry_t;

  // High bit of the predictor index slice for a given index width.
  function automatic int idx_hi(input int bp_width);
    return bp_width + IDX_LO - 1;
  endfunction

endpackage

// File: rtl/bp_hint_match.sv
// Youngest-wins alias match over the FIFO slots plus the in-flight update.
// Slot DEPTH is the in-flight register and is always the oldest candidate.
module bp_hint_match #(
  parameter int DEPTH = 4,
  parameter int KW    = 2
) (
  input  logic [DEPTH:0][KW-1:0]     cand_key_i,
  input  logic [DEPTH:0]             cand_vld_i,
  input  logic [DEPTH:0]             cand_tkn_i,
  input  logic [$clog2(DEPTH)-1:0]   head_i,
  input  logic [KW-1:0]              query_key_i,
  output logic                       hint_valid_o,
  output logic                       hint_taken_o
);

  localparam int AW = $clog2(DEPTH);

  always_comb begin
    logic [AW-1:0] slot;
    slot         = '0;
    hint_valid_o = 1'b0;
    hint_taken_o = 1'b0;
    if (cand_vld_i[DEPTH] && cand_key_i[DEPTH] == query_key_i) begin
      hint_valid_o = 1'b1;
      hint_taken_o = cand_tkn_i[DEPTH];
    end
    // Walk oldest to youngest from head so the last match is the youngest.
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_i + AW'(k);
      if (cand_vld_i[slot] && cand_key_i[slot] == query_key_i) begin
        hint_valid_o = 1'b1;
        hint_taken_o = cand_tkn_i[slot];
      end
    end
  end

endmodule

// File: rtl/bp_update_scheduler.sv
// Queues up to two committed branch outcomes per cycle and feeds the
// predictor's single update port one per cycle, with an IF alias hint.
module bp_update_scheduler
  import bp_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int BP_WIDTH = BP_WIDTH_DFLT
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       req0_valid,
  input  logic [31:0]                req0_PC,
  input  logic                       req0_taken,
  input  logic                       req1_valid,
  input  logic [31:0]                req1_PC,
  input  logic                       req1_taken,
  output logic                       full_out,
  output logic                       overflow_err,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       update_en,
  output logic [31:0]                update_PC,
  output logic                       update_result,
  input  logic [31:0]                query_PC,
  output logic                       hint_valid,
  output logic                       hint_taken
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int IHI = idx_hi(BP_WIDTH);

  bp_entry_t     mem_q [DEPTH];
  logic [AW-1:0] head_q, tail_q, tail_p1;
  logic [CW-1:0] count_q, count_d, free;
  logic          full_q, full_d, ovf_q;
  logic          upd_en_q, upd_res_q;
  logic [31:0]   upd_pc_q;

  logic          pop, drop;
  logic [1:0]    n_req, n_push;
  bp_entry_t     first, second;

  always_comb begin
    n_req   = 2'(req0_valid) + 2'(req1_valid);
    first   = req0_valid ? bp_entry_t'{req0_PC, req0_taken}
                         : bp_entry_t'{req1_PC, req1_taken};
    second  = bp_entry_t'{req1_PC, req1_taken};
    pop     = rdy_in && (count_q != '0);
    // A same-edge pop frees its slot for this edge's pushes.
    free    = CW'(DEPTH) - count_q + CW'(pop);
    n_push  = 2'd0;
    if (rdy_in) begin
      if (n_req == 2'd2)
        n_push = (free >= CW'(2)) ? 2'd2 : ((free >= CW'(1)) ? 2'd1 : 2'd0);
      else if (n_req == 2'd1)
        n_push = (free >= CW'(1)) ? 2'd1 : 2'd0;
    end
    drop    = rdy_in && (n_push != n_req);
    tail_p1 = tail_q + AW'(1);
    count_d = count_q + CW'(n_push) - CW'(pop);
    full_d  = (CW'(DEPTH) - count_d) < CW'(2);
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (n_push != 2'd0) mem_q[tail_q]  <= first;
      if (n_push == 2'd2) mem_q[tail_p1] <= second;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      upd_en_q  <= 1'b0;
      upd_pc_q  <= '0;
      upd_res_q <= 1'b0;
    end else if (rdy_in) begin
      head_q   <= pop ? head_q + AW'(1) : head_q;
      tail_q   <= tail_q + AW'(n_push);
      count_q  <= count_d;
      full_q   <= full_d;
      upd_en_q <= pop;
      if (drop) ovf_q <= 1'b1;
      if (pop) begin
        upd_pc_q  <= mem_q[head_q].pc;
        upd_res_q <= mem_q[head_q].taken;
      end
    end
  end

  logic [DEPTH:0][BP_WIDTH-1:0] cand_key;
  logic [DEPTH:0]               cand_vld, cand_tkn;

  always_comb begin
    logic [AW-1:0] rel;
    rel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel         = AW'(i) - head_q;
      cand_vld[i] = CW'(rel) < count_q;
      cand_key[i] = mem_q[i].pc[IHI:IDX_LO];
      cand_tkn[i] = mem_q[i].taken;
    end
    cand_vld[DEPTH] = upd_en_q;
    cand_key[DEPTH] = upd_pc_q[IHI:IDX_LO];
    cand_tkn[DEPTH] = upd_res_q;
  end

  bp_hint_match #(.DEPTH(DEPTH), .KW(BP_WIDTH)) u_hint (
    .cand_key_i   (cand_key),
    .cand_vld_i   (cand_vld),
    .cand_tkn_i   (cand_tkn),
    .head_i       (head_q),
    .query_key_i  (query_PC[IHI:IDX_LO]),
    .hint_valid_o (hint_valid),
    .hint_taken_o (hint_taken)
  );

  assign full_out      = full_q;
  assign overflow_err  = ovf_q;
  assign count_out     = count_q;
  assign update_en     = upd_en_q;
  assign update_PC     = upd_pc_q;
  assign update_result = upd_res_q;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler with hand-computed expectations.
module tb_bp_update_scheduler;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        v0, t0, v1, t1;
  logic [31:0] p0, p1, qpc;
  logic        full_out, overflow_err, update_en, update_result;
  logic        hint_valid, hint_taken;
  logic [2:0]  count_out;
  logic [31:0] update_PC;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  bp_update_scheduler #(.DEPTH(4), .BP_WIDTH(2)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .req0_valid(v0), .req0_PC(p0), .req0_taken(t0),
    .req1_valid(v1), .req1_PC(p1), .req1_taken(t1),
    .full_out(full_out), .overflow_err(overflow_err), .count_out(count_out),
    .update_en(update_en), .update_PC(update_PC), .update_result(update_result),
    .query_PC(qpc), .hint_valid(hint_valid), .hint_taken(hint_taken)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic a, input logic [31:0] pa, input logic ta,
                     input logic b, input logic [31:0] pb, input logic tb);
    v0 = a; p0 = pa; t0 = ta;
    v1 = b; p1 = pb; t1 = tb;
  endtask

  task automatic upd(input string tag, input logic en, input logic [31:0] pc,
                     input logic res, input logic [2:0] cnt);
    chk({tag, ".en"},  {31'd0, update_en}, {31'd0, en});
    chk({tag, ".pc"},  update_PC, pc);
    chk({tag, ".res"}, {31'd0, update_result}, {31'd0, res});
    chk({tag, ".cnt"}, {29'd0, count_out}, {29'd0, cnt});
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; qpc = 32'h0;
    req(0, 0, 0, 0, 0, 0);
    #3;
    upd("rst", 0, 32'h0, 0, 3'd0);
    chk("rst.full", {31'd0, full_out}, 32'd0);
    chk("rst.ovf",  {31'd0, overflow_err}, 32'd0);
    chk("rst.hint", {31'd0, hint_valid}, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // single push, two-edge latency
    req(1, 32'h100, 1, 0, 0, 0);
    tick();
    req(0, 0, 0, 0, 0, 0);
    upd("s1.e1", 0, 32'h0, 0, 3'd1);
    tick();
    upd("s1.e2", 1, 32'h100, 1, 3'd0);
    tick();
    upd("s1.e3", 0, 32'h100, 1, 3'd0);

    // dual push drains in order
    req(1, 32'h200, 1, 1, 32'h204, 0);
    tick();
    req(0, 0, 0, 0, 0, 0);
    upd("d.e1", 0, 32'h100, 1, 3'd2);
    tick();
    upd("d.e2", 1, 32'h200, 1, 3'd1);
    tick();
    upd("d.e3", 1, 32'h204, 0, 3'd0);
    tick();
    chk("d.e4.en", {31'd0, update_en}, 32'd0);

    // fill, overflow, wrap
    req(1, 32'h300, 1, 1, 32'h304, 0);
    tick();
    chk("f.a.full", {31'd0, full_out}, 32'd0);
    chk("f.a.cnt", {29'd0, count_out}, 32'd2);
    req(1, 32'h308, 1, 1, 32'h30C, 0);
    tick();
    chk("f.b.full", {31'd0, full_out}, 32'd1);
    upd("f.b", 1, 32'h300, 1, 3'd3);
    req(1, 32'h310, 1, 1, 32'h314, 0);
    tick();
    upd("f.c", 1, 32'h304, 0, 3'd4);
    chk("f.c.ovf", {31'd0, overflow_err}, 32'd0);
    req(1, 32'h318, 1, 1, 32'h31C, 0);
    tick();
    req(0, 0, 0, 0, 0, 0);
    upd("f.d", 1, 32'h308, 1, 3'd4);
    chk("f.d.ovf",  {31'd0, overflow_err}, 32'd1);
    chk("f.d.full", {31'd0, full_out}, 32'd1);
    tick();
    upd("f.e", 1, 32'h30C, 0, 3'd3);
    chk("f.e.full", {31'd0, full_out}, 32'd1);
    tick();
    upd("f.f", 1, 32'h310, 1, 3'd2);
    chk("f.f.full", {31'd0, full_out}, 32'd0);
    tick();
    upd("f.g", 1, 32'h314, 0, 3'd1);
    tick();
    upd("f.h", 1, 32'h318, 1, 3'd0);
    tick();
    chk("f.i.en", {31'd0, update_en}, 32'd0);
    chk("f.i.ovf", {31'd0, overflow_err}, 32'd1);

    // alias hint
    req(1, 32'h10, 1, 1, 32'h30, 0);
    tick();
    req(0, 0, 0, 0, 0, 0);
    qpc = 32'h50; #1;
    chk("h.q50.v", {31'd0, hint_valid}, 32'd1);
    chk("h.q50.t", {31'd0, hint_taken}, 32'd0);
    qpc = 32'h14; #1;
    chk("h.q14.v", {31'd0, hint_valid}, 32'd0);
    qpc = 32'h18; #1;
    chk("h.q18.v", {31'd0, hint_valid}, 32'd0);
    tick();
    qpc = 32'h50; #1;
    chk("h.fl.v", {31'd0, hint_valid}, 32'd1);
    chk("h.fl.t", {31'd0, hint_taken}, 32'd0);
    tick();
    req(1, 32'h44, 1, 0, 0, 0);
    tick();
    req(0, 0, 0, 0, 0, 0);
    qpc = 32'h84; #1;
    chk("h.q84.v", {31'd0, hint_valid}, 32'd1);
    chk("h.q84.t", {31'd0, hint_taken}, 32'd1);
    tick(); tick();
    chk("h.idle.v", {31'd0, hint_valid}, 32'd0);

    // freeze with rdy low
    req(1, 32'h500, 1, 1, 32'h504, 0);
    tick();
    req(0, 0, 0, 1, 32'h508, 1);
    tick();
    upd("r.pre", 1, 32'h500, 1, 3'd2);
    rdy = 1'b0;
    req(1, 32'h600, 1, 1, 32'h604, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      upd("r.frz", 1, 32'h500, 1, 3'd2);
      chk("r.frz.full", {31'd0, full_out}, 32'd0);
    end
    rdy = 1'b1;
    req(0, 0, 0, 0, 0, 0);
    tick();
    upd("r.1", 1, 32'h504, 0, 3'd1);
    tick();
    upd("r.2", 1, 32'h508, 1, 3'd0);
    tick();
    chk("r.3.en", {31'd0, update_en}, 32'd0);

    // asynchronous reset mid-cycle
    req(1, 32'h700, 1, 1, 32'h704, 0);
    tick();
    req(1, 32'h708, 1, 1, 32'h70C, 0);
    tick();
    req(0, 0, 0, 0, 0, 0);
    upd("a.pre", 1, 32'h700, 1, 3'd3);
    qpc = 32'h700;
    #2 rst = 1'b1;
    #1;
    upd("a.rst", 0, 32'h0, 0, 3'd0);
    chk("a.rst.full", {31'd0, full_out}, 32'd0);
    chk("a.rst.ovf",  {31'd0, overflow_err}, 32'd0);
    chk("a.rst.hint", {31'd0, hint_valid}, 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    upd("a.post", 0, 32'h0, 0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bp_update_scheduler.md
# bp_update_scheduler

Serialises branch-resolution updates from the RoB commit stage into the single update port of `Branch_Predictor`. The RoB may retire up to two branches per cycle. This block buffers their outcomes in a small in-order FIFO and drains exactly one per cycle into the predictor. It also gives IF a forwarding hint when a queried PC aliases a still-pending update. It sits between RoB commit and the predictor, next to IF.

## Interface
- `DEPTH`, 4: FIFO entries. Power of two, ≥ 2.
- `BP_WIDTH`, 2: predictor index width. Must match the predictor instance.
- `clk_in` in 1: single clock.
- `rst_in` in 1: reset, asynchronous, active-high.
- `rdy_in` in 1: global run enable. Low freezes all state and outputs.
- `req0_valid` in 1: commit slot 0 retires a branch. Older of the two slots.
- `req0_PC` in 32: PC of slot-0 branch.
- `req0_taken` in 1: resolved outcome of slot 0. 1 = jumped.
- `req1_valid` / `req1_PC` / `req1_taken` in 1/32/1: same fields for commit slot 1, the younger slot.
- `full_out` out 1: registered. High when free slots < 2. RoB must not retire branches while high.
- `overflow_err` out 1: sticky. Set when a push is dropped.
- `count_out` out clog2(DEPTH)+1: registered occupancy.
- `update_en` out 1: registered. Drives predictor `update_en`.
- `update_PC` out 32: registered. Drives predictor `update_PC`.
- `update_result` out 1: registered. Drives predictor `update_result`.
- `query_PC` in 32: IF query PC. Same value as the predictor `query_PC`.
- `hint_valid` out 1: combinational. A pending update aliases `query_PC`.
- `hint_taken` out 1: combinational. Outcome of the youngest aliasing pending update.

## Operation
- Entry format is {PC[31:0], taken}. Storage is a circular buffer with head/tail pointers. Pointers wrap modulo DEPTH. Occupancy is tracked by a separate counter, so full and empty are unambiguous.
- Push, per active cycle (`rdy_in`=1):
  - Slot 0 is enqueued before slot 1.
  - If only `req1_valid` is high, it takes a single slot.
  - If free space is short, the younger request is dropped first, and `overflow_err` is set. It stays set until reset.
- Pop, per active cycle: if occupancy at the start of the cycle is > 0, the head entry is popped. `update_en`, `update_PC` and `update_result` are loaded from it at the same edge. Otherwise `update_en` is loaded with 0, and `update_PC`/`update_result` hold.
- Push and pop in the same cycle are legal. Next count = count + pushes − pop.
- Entries pushed at an edge are not poppable at that same edge. There is no empty-queue bypass.
- `full_out` is registered from the next count: (DEPTH − next_count) < 2.
- Hint match key is PC[BP_WIDTH+1:2], the predictor update index.
  - Candidates are all valid FIFO entries plus the in-flight `update_*` register when `update_en` is high. The in-flight register counts as oldest.
  - `hint_valid` = any candidate key equals `query_PC[BP_WIDTH+1:2]`.
  - `hint_taken` = taken bit of the youngest matching candidate, else 0.
- `rdy_in`=0: no push, no pop. All registers, including `update_en`, hold. This keeps updates in lockstep with the predictor, which also pauses.

## Timing
- Reset, asynchronous: pointers 0, count 0, `update_en` 0, `update_PC` 0, `update_result` 0, `full_out` 0, `overflow_err` 0.
- Reset asserted mid-operation discards all queued entries immediately, without waiting for a clock edge.
- Latency: a branch pushed at edge E pops at edge E+1 at the earliest. `update_en` is high in cycle E+1..E+2, and the predictor samples it at edge E+2.
- Throughput: 1 update/cycle. Sustained dual pushes fill the FIFO, and `full_out` throttles the RoB.
- `full_out` and `count_out` reflect state after the most recent active edge.
- Hint outputs are purely combinational from current state and `query_PC`, with zero-cycle latency.

## Structure
- Shared package `bp_pkg`:
  - `BP_WIDTH` default.
  - Entry struct/width constant (33 bits).
  - Index slice helper constants (low bit 2, high bit BP_WIDTH+1).
- One sub-module: `bp_hint_match`. It is a combinational youngest-first priority match over DEPTH+1 candidates, taking keys, valids and taken bits, with head-relative ordering. FIFO storage stays in the top level.

## Test plan
- Reset → all outputs 0. Single push {PC=0x100, taken=1} at edge 1 → `update_en`=1, `update_PC`=0x100, `update_result`=1 during cycle after edge 2. `update_en`=0 the following cycle.
- Dual push {0x200,1},{0x204,0} on one cycle → updates appear on consecutive cycles in order 0x200 then 0x204. `count_out` goes 2→1→0.
- Four consecutive dual pushes with DEPTH=4 → `full_out`=1 once count ≥ 3. A forced push at count=4 sets `overflow_err`=1 and drops the younger request. Pointer wrap preserves order.
- Pending entries {0x10,1} then {0x30,0} (both index 0b00 with BP_WIDTH=2), `query_PC`=0x50 → `hint_valid`=1, `hint_taken`=0. `query_PC`=0x14 → `hint_valid`=0.
- `rdy_in`=0 for 3 cycles while `update_en`=1 and count=2 → all outputs frozen, pushes ignored. Resume → drain continues without loss or duplication.
- Assert `rst_in` between clock edges with count=3 → outputs and count go to 0 immediately. No stale update appears after release.
